// File: rtl/ann_layer_mac.sv
// Time-multiplexed fully-connected perceptron layer: N_OUT neurons of N_IN inputs sharing one signed fixed-point MAC.
// Optional macro ANN_SAT_EN: saturating product truncation and accumulation instead of wrap-around.
module ann_layer_mac #(
    parameter int unsigned W     = 32,
    parameter int unsigned FRAC  = 24,
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 3,
    parameter int unsigned ACT   = 1,
    parameter int unsigned AW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*W-1:0]     in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*W-1:0]    out_y,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [W-1:0]          wr_data,
    output logic                  busy
);

    localparam int unsigned NC   = N_OUT * (N_IN + 1);
    localparam int unsigned BASE = N_OUT * N_IN;
    localparam int unsigned CW   = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic signed [W-1:0] coef [NC];
    logic signed [W-1:0] xr   [N_IN];
    logic signed [W-1:0] acc;
    logic [IW-1:0]       idx;
    logic [JW-1:0]       j;

    logic [CW-1:0]         w_addr;
    logic [CW-1:0]         b_addr;
    logic                  wr_b0;
    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]   p;
    logic signed [W-1:0]   acc_sum;
    logic signed [W-1:0]   y_act;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MAC;
            MAC:     if (idx == IW'(N_IN - 1)) state_nxt = WRITE;
            WRITE:   state_nxt = (j == JW'(N_OUT - 1)) ? DONE : MAC;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared MAC datapath; a bias-0 write coinciding with the accept is forwarded into acc
    always_comb begin
        w_addr = CW'(j) * CW'(N_IN) + CW'(idx);
        b_addr = CW'(BASE) + CW'(j) + CW'(1);
        wr_b0  = wr_en && (wr_addr == AW'(BASE));
        prod   = $signed((2*W)'(xr[idx])) * $signed((2*W)'(coef[w_addr]));
        y_act  = ((ACT != 0) && acc[W-1]) ? '0 : acc;
    end

`ifdef ANN_SAT_EN
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic signed [2*W-1:0] prod_sh;
    logic [W:0]            hi;
    logic [W:0]            sum_ext;

    // Clamp the shifted product and the running sum to the W-bit signed range
    always_comb begin
        prod_sh = prod >>> FRAC;
        hi      = prod_sh[2*W-1:W-1];
        if ((&hi) || !(|hi)) begin
            p = prod_sh[W-1:0];
        end else begin
            p = prod_sh[2*W-1] ? SMIN : SMAX;
        end
        sum_ext = {acc[W-1], acc} + {p[W-1], p};
        if (sum_ext[W] != sum_ext[W-1]) begin
            acc_sum = sum_ext[W] ? SMIN : SMAX;
        end else begin
            acc_sum = sum_ext[W-1:0];
        end
    end
`else
    always_comb begin
        p       = W'(prod >>> FRAC);
        acc_sum = acc + p;
    end
`endif

    // Coefficients, operand latch, accumulator, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NC; k++) coef[k] <= '0;
            for (int unsigned i = 0; i < N_IN; i++) xr[i] <= '0;
            acc       <= '0;
            idx       <= '0;
            j         <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            in_ready  <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    for (int unsigned k = 0; k < NC; k++) begin
                        if (wr_en && (wr_addr == AW'(k))) coef[k] <= wr_data;
                    end
                    if (in_valid) begin
                        for (int unsigned i = 0; i < N_IN; i++) xr[i] <= in_x[i*W +: W];
                        acc <= wr_b0 ? wr_data : coef[CW'(BASE)];
                        idx <= '0;
                        j   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    idx <= idx + IW'(1);
                end
                WRITE: begin
                    for (int unsigned k = 0; k < N_OUT; k++) begin
                        if (j == JW'(k)) out_y[k*W +: W] <= y_act;
                    end
                    if (j != JW'(N_OUT - 1)) begin
                        j   <= j + JW'(1);
                        acc <= coef[b_addr];
                        idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ann_layer_mac.sv
// Scoreboard bench for ann_layer_mac: identity and ReLU instances driven in parallel.
module tb_ann_layer_mac;

    localparam int unsigned W     = 32;
    localparam int unsigned N_IN  = 2;
    localparam int unsigned N_OUT = 3;
    localparam int unsigned AW    = 8;
    localparam int unsigned XW    = N_IN * W;
    localparam int unsigned YW    = N_OUT * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [XW-1:0] in_x;
    logic          out_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    logic          in_ready1, out_valid1, busy1;
    logic          in_ready0, out_valid0, busy0;
    logic [YW-1:0] out_y1, out_y0;

    int n_checks = 0;
    int n_errors = 0;
    logic [YW-1:0] q1 [$];
    logic [YW-1:0] q0 [$];

    always #5 clk = ~clk;

    ann_layer_mac #(.W(W), .FRAC(24), .N_IN(N_IN), .N_OUT(N_OUT), .ACT(1), .AW(AW)) u_act1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_x(in_x),
        .out_valid(out_valid1), .out_ready(out_ready), .out_y(out_y1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy1)
    );

    ann_layer_mac #(.W(W), .FRAC(24), .N_IN(N_IN), .N_OUT(N_OUT), .ACT(0), .AW(AW)) u_act0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_x(in_x),
        .out_valid(out_valid0), .out_ready(out_ready), .out_y(out_y0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy0)
    );

    task automatic check(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [YW-1:0] yv(input logic [W-1:0] y0, input logic [W-1:0] y1,
                                         input logic [W-1:0] y2);
        return {y2, y1, y0};
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // One computation: accept, latency, optional backpressure, handshake and scoreboard compare
    task automatic run(input logic [XW-1:0] x, input logic [YW-1:0] e1, input logic [YW-1:0] e0,
                       input int hold, input bit busy_wr, input bit acc_wr, input logic [W-1:0] acc_b0);
        int lat;
        logic [YW-1:0] p1, p0;
        check("in_ready_idle", YW'({in_ready1, in_ready0}), YW'(2'b11));
        in_x     = x;
        in_valid = 1'b1;
        if (acc_wr) begin
            wr_en   = 1'b1;
            wr_addr = 8'd6;
            wr_data = acc_b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wr_en    = 1'b0;
        q1.push_back(e1);
        q0.push_back(e0);
        check("accept_flags", YW'({busy1, busy0, in_ready1, in_ready0}), YW'(4'b1100));
        lat = 0;
        while (!out_valid1 && lat < 40) begin
            if (busy_wr && lat == 1) begin
                wr_en   = 1'b1;
                wr_addr = 8'd0;
                wr_data = 32'h02000000;
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            lat++;
        end
        check("latency", YW'(lat), YW'(9));
        check("out_valid_act0", YW'(out_valid0), YW'(1));
        for (int c = 0; c < hold; c++) begin
            check("hold_y_act1", out_y1, q1[0]);
            check("hold_flags", YW'({out_valid1, busy1, in_ready1}), YW'(3'b110));
            in_valid = (c == 3);
            if (c == 3) in_x = ~x;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (q1.size() == 0 || q0.size() == 0) begin
            check("scoreboard_empty", YW'(q1.size()), YW'(1));
        end else begin
            p1 = q1.pop_front();
            p0 = q0.pop_front();
            check("y_act1", out_y1, p1);
            check("y_act0", out_y0, p0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_handshake", YW'({out_valid1, out_valid0, busy1, busy0, in_ready1, in_ready0}),
              YW'(6'b000011));
    endtask

    logic [XW-1:0] x1, xo;
    logic [W-1:0]  ov1, ov0;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        x1 = {32'h05000000, 32'h08000000};
        xo = {32'h7F000000, 32'h7F000000};
`ifdef ANN_SAT_EN
        ov1 = 32'h7FFFFFFF;
        ov0 = 32'h7FFFFFFF;
`else
        ov1 = 32'h00000000;
        ov0 = 32'hFE000000;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", out_y1 | out_y0, '0);
        check("reset_flags", YW'({out_valid1, busy1, in_ready1, out_valid0, busy0, in_ready0}),
              YW'(6'b001001));
        reset = 1'b1;
        @(posedge clk); #1;

        wr(8'd0, 32'h01000000); wr(8'd1, 32'h01000000);
        wr(8'd2, 32'hFF000000); wr(8'd3, 32'h00000000);
        wr(8'd4, 32'h00800000); wr(8'd5, 32'h00000000);
        wr(8'd6, 32'h00000000); wr(8'd7, 32'h00000000); wr(8'd8, 32'h01000000);

        run(x1, yv(32'h0D000000, 32'h00000000, 32'h05000000),
                yv(32'h0D000000, 32'hF8000000, 32'h05000000), 10, 1'b0, 1'b0, '0);
        run(x1, yv(32'h0D000000, 32'h00000000, 32'h05000000),
                yv(32'h0D000000, 32'hF8000000, 32'h05000000), 0, 1'b1, 1'b0, '0);
        wr(8'd0, 32'h02000000);
        run(x1, yv(32'h15000000, 32'h00000000, 32'h05000000),
                yv(32'h15000000, 32'hF8000000, 32'h05000000), 0, 1'b0, 1'b0, '0);
        run(x1, yv(32'h16000000, 32'h00000000, 32'h05000000),
                yv(32'h16000000, 32'hF8000000, 32'h05000000), 0, 1'b0, 1'b1, 32'h01000000);
        wr(8'd9, 32'h7F000000);
        wr(8'd255, 32'h7F000000);
        run(x1, yv(32'h16000000, 32'h00000000, 32'h05000000),
                yv(32'h16000000, 32'hF8000000, 32'h05000000), 0, 1'b0, 1'b0, '0);

        wr(8'd0, 32'h01000000);
        wr(8'd6, 32'h00000000);
        run(xo, yv(ov1, 32'h00000000, 32'h40800000),
                yv(ov0, 32'h81000000, 32'h40800000), 0, 1'b0, 1'b0, '0);

        // Abort mid-computation with an asynchronous reset
        run(x1, yv(32'h0D000000, 32'h00000000, 32'h05000000),
                yv(32'h0D000000, 32'hF8000000, 32'h05000000), 0, 1'b0, 1'b0, '0);
        in_x     = x1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_y", out_y1 | out_y0, '0);
        check("abort_flags", YW'({out_valid1, busy1, in_ready1, out_valid0, busy0, in_ready0}),
              YW'(6'b001001));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run(x1, '0, '0, 0, 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ann_layer_mac.md
Name: ann_layer_mac

Overview:
- Parametrised, time-multiplexed fully-connected perceptron layer.
- Generalises the fixed 2-in/3-out and 3-in/2-out layers to N_IN inputs and N_OUT neurons, all sharing one signed fixed-point MAC.
- Weights and biases are written through a register-style load port; no hierarchical poking.
- Input vector uses a valid/ready handshake; output vector uses a valid/ready handshake. Layers chain directly.

Parameters:
W, 32, data word width (signed two's complement)
FRAC, 24, fractional bits (default Q8.24; 1.0 = 0x01000000)
N_IN, 2, inputs per neuron
N_OUT, 3, neurons in layer
ACT, 1, activation: 0 = identity, 1 = ReLU
AW, 8, load-port address width; must satisfy 2^AW >= N_OUT*(N_IN+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector (high in IDLE only)
in_x  in  N_IN*W  input vector; element i at bits [i*W +: W]
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts result
out_y  out  N_OUT*W  result vector; neuron j at bits [j*W +: W]
wr_en  in  1  coefficient write strobe
wr_addr  in  AW  addr j*N_IN+i = weight w[j][i]; addr N_OUT*N_IN+j = bias b[j]
wr_data  in  W  coefficient value
busy  out  1  high in MAC, WRITE and DONE states

Behaviour:
- Reset (reset=0, async): state=IDLE; out_y=0; out_valid=0; all weights/biases=0; x latch, acc, idx and neuron counters=0. Reset mid-computation aborts; no partial result is ever presented.
- in_ready = (state==IDLE), combinational.
- States:
  - IDLE: on in_valid: latch in_x, acc=b[0], j=0, idx=0 -> MAC.
  - MAC: acc = acc + p, where p = (x[idx]*w[j][idx]) arithmetic-shifted right by FRAC (2W-bit signed product, floor rounding), low W bits kept. idx++. When idx==N_IN-1 -> WRITE.
  - WRITE: out_y[j] = act(acc). If j==N_OUT-1 -> DONE. Else j++, acc=b[j], idx=0 -> MAC.
  - DONE: out_valid=1; held with out_y stable until out_ready=1. On handshake: out_valid=0 -> IDLE.
- Latency: out_valid rises exactly N_OUT*(N_IN+1) clock edges after the input-accept edge (default 9).
- Addition wraps modulo 2^W by default.
- act(): ACT=0 passes through; ACT=1 outputs 0 when acc[W-1]=1.
- out_y holds the previous result until overwritten per-neuron in WRITE. Downstream samples it only while out_valid=1.
- Load port:
  - wr_en is honoured only in IDLE; writes in any other state are dropped silently.
  - wr_addr >= N_OUT*(N_IN+1) is ignored.
  - A write in the same cycle as an in_valid accept takes effect before the next computation starts. The accepted computation uses the new value, because the coefficient write lands at the accept edge and MAC reads start one edge later.
- in_valid outside IDLE is ignored. No queueing.

Optional Feature:
- Macro ANN_SAT_EN.
- Defined:
  - Product truncation saturates to [-2^(W-1), 2^(W-1)-1] when the shifted product exceeds W bits.
  - Each accumulate saturates to the same range.
  - Bias load into acc is unchanged.
- Undefined: wrap-around arithmetic as above; no saturation logic synthesised.

Test Plan:
1. Defaults (ACT=1). Load w0=(0x01000000,0x01000000), b0=0; w1=(0xFF000000,0), b1=0; w2=(0x00800000,0), b2=0x01000000. Apply x=(0x08000000,0x05000000) -> out_y0=0x0D000000, out_y1=0x00000000 (ReLU of -8), out_y2=0x05000000; out_valid exactly 9 edges after accept.
2. Same stimulus with ACT=0 -> out_y1=0xF8000000; other outputs unchanged.
3. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_y stable, in_ready=0, busy=1, a pulsed in_valid is ignored. out_ready=1 -> one-cycle handshake, then IDLE and in_ready=1.
4. Overflow: x=(0x7F000000,0x7F000000), w0=(0x01000000,0x01000000), b0=0, ACT=0. Without ANN_SAT_EN -> out_y0=0xFE000000; with ANN_SAT_EN -> out_y0=0x7FFFFFFF.
5. Write w0[0]=0x02000000 while busy -> dropped; rerun test 1 -> out_y0 still 0x0D000000. Same write in IDLE, then rerun -> out_y0=0x15000000.
6. Drive reset=0 asynchronously mid-MAC (edge 4) -> out_valid=0 and out_y=0 immediately. After release, in_ready=1; coefficients read 0, so rerun gives out_y=0 on all neurons.
